// File: rtl/mem_ctrl_pkg.sv
// Shared types for the LSU-to-memory arbiter and its channels.
// MEM_CONTROLLER_WRITE_EN adds the write states; without it the build is read-only.
package mem_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    CH_IDLE           = 3'd0,
    CH_READ_WAITING   = 3'd1,
    CH_READ_RELAYING  = 3'd2
`ifdef MEM_CONTROLLER_WRITE_EN
    ,
    CH_WRITE_WAITING  = 3'd3,
    CH_WRITE_RELAYING = 3'd4
`endif
  } ch_state_e;

endpackage

// File: rtl/mem_channel.sv
// One memory channel: request FSM, latched request and round-robin pointer.
// MEM_CONTROLLER_WRITE_EN enables the write path; otherwise write outputs are 0.
module mem_channel
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_W         = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 grant_i,
  input  logic                 grant_write_i,
  input  logic [IDX_W-1:0]     grant_idx_i,
  input  logic [ADDR_BITS-1:0] grant_addr_i,
  input  logic [DATA_BITS-1:0] grant_data_i,
  input  logic                 cons_read_valid_i,
  input  logic                 cons_write_valid_i,
  output logic [STATE_W-1:0]   state_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic [IDX_W-1:0]     ptr_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 release_o,
  output logic                 mem_read_valid_o,
  output logic [ADDR_BITS-1:0] mem_read_address_o,
  input  logic                 mem_read_ready_i,
  input  logic [DATA_BITS-1:0] mem_read_data_i,
  output logic                 mem_write_valid_o,
  output logic [ADDR_BITS-1:0] mem_write_address_o,
  output logic [DATA_BITS-1:0] mem_write_data_o,
  input  logic                 mem_write_ready_i
);

  ch_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  function automatic logic [IDX_W-1:0] next_idx(
    input logic [IDX_W-1:0] i
  );
    return (i == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    release_o = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (grant_i) begin
          idx_d  = grant_idx_i;
          addr_d = grant_addr_i;
          data_d = grant_data_i;
`ifdef MEM_CONTROLLER_WRITE_EN
          state_d = grant_write_i ? CH_WRITE_WAITING
                                  : CH_READ_WAITING;
`else
          state_d = CH_READ_WAITING;
`endif
        end
      end
      CH_READ_WAITING: begin
        if (mem_read_ready_i) begin
          data_d  = mem_read_data_i;
          state_d = CH_READ_RELAYING;
        end
      end
      CH_READ_RELAYING: begin
        if (!cons_read_valid_i) begin
          state_d   = CH_IDLE;
          release_o = 1'b1;
          ptr_d     = next_idx(idx_q);
        end
      end
`ifdef MEM_CONTROLLER_WRITE_EN
      CH_WRITE_WAITING: begin
        if (mem_write_ready_i) state_d = CH_WRITE_RELAYING;
      end
      CH_WRITE_RELAYING: begin
        if (!cons_write_valid_i) begin
          state_d   = CH_IDLE;
          release_o = 1'b1;
          ptr_d     = next_idx(idx_q);
        end
      end
`endif
      default: state_d = CH_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;
  assign ptr_o   = ptr_q;
  assign data_o  = data_q;

  assign mem_read_valid_o   = (state_q == CH_READ_WAITING);
  assign mem_read_address_o = mem_read_valid_o ? addr_q : '0;

`ifdef MEM_CONTROLLER_WRITE_EN
  assign mem_write_valid_o   = (state_q == CH_WRITE_WAITING);
  assign mem_write_address_o = mem_write_valid_o ? addr_q : '0;
  assign mem_write_data_o    = mem_write_valid_o ? data_q : '0;
`else
  logic unused_wr;
  assign unused_wr = ^{grant_write_i, cons_write_valid_i,
                       mem_write_ready_i};
  assign mem_write_valid_o   = 1'b0;
  assign mem_write_address_o = '0;
  assign mem_write_data_o    = '0;
`endif

endmodule

// File: rtl/mem_controller.sv
// Arbitrates per-thread LSU requests onto NUM_CHANNELS memory channels.
// MEM_CONTROLLER_WRITE_EN builds the data-memory variant with writes.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int IDX_W =
    (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [STATE_W-1:0]   ch_state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]     ch_idx;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]     ch_ptr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_data;
  logic [NUM_CHANNELS-1:0]                ch_release;
  logic [NUM_CHANNELS-1:0]                ch_rd_valid;
  logic [NUM_CHANNELS-1:0]                ch_wr_valid;

  logic [NUM_CHANNELS-1:0]                grant_v;
  logic [NUM_CHANNELS-1:0]                grant_wr;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]     grant_idx;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_data;

  logic [NUM_CONSUMERS-1:0] busy_q, busy_d;
  logic [NUM_CONSUMERS-1:0] claim;
  logic [NUM_CONSUMERS-1:0] pending;
  int                       sel_j;

`ifdef MEM_CONTROLLER_WRITE_EN
  assign pending = consumer_read_valid | consumer_write_valid;
`else
  logic unused_wr;
  assign unused_wr = ^{consumer_write_valid, consumer_write_address,
                       consumer_write_data};
  assign pending = consumer_read_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Lower channels claim first; claims accumulate so no consumer
  // can be granted to two channels in the same cycle.
  always_comb begin
    claim      = busy_q;
    sel_j      = 0;
    grant_v    = '0;
    grant_wr   = '0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == CH_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          sel_j = (int'(ch_ptr[c]) + k) % NUM_CONSUMERS;
          if (!grant_v[c] && pending[sel_j] && !claim[sel_j]) begin
            grant_v[c]    = 1'b1;
            claim[sel_j]  = 1'b1;
            grant_idx[c]  = IDX_W'(sel_j);
`ifdef MEM_CONTROLLER_WRITE_EN
            grant_wr[c]   = !consumer_read_valid[sel_j];
            grant_addr[c] = consumer_read_valid[sel_j]
                          ? consumer_read_address[sel_j]
                          : consumer_write_address[sel_j];
            grant_data[c] = consumer_write_data[sel_j];
`else
            grant_addr[c] = consumer_read_address[sel_j];
`endif
          end
        end
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_release[c]) busy_d[ch_idx[c]] = 1'b0;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_v[c]) busy_d[grant_idx[c]] = 1'b1;
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_state[c] == CH_READ_RELAYING) begin
        consumer_read_ready[ch_idx[c]] = 1'b1;
        consumer_read_data[ch_idx[c]]  = ch_data[c];
      end
`ifdef MEM_CONTROLLER_WRITE_EN
      if (ch_state[c] == CH_WRITE_RELAYING) begin
        consumer_write_ready[ch_idx[c]] = 1'b1;
      end
`endif
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign ch_rd_valid[c] = consumer_read_valid[ch_idx[c]];
`ifdef MEM_CONTROLLER_WRITE_EN
    assign ch_wr_valid[c] = consumer_write_valid[ch_idx[c]];
`else
    assign ch_wr_valid[c] = 1'b0;
`endif

    mem_channel #(
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .IDX_W        (IDX_W),
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS)
    ) u_ch (
      .clk                (clk),
      .reset              (reset),
      .grant_i            (grant_v[c]),
      .grant_write_i      (grant_wr[c]),
      .grant_idx_i        (grant_idx[c]),
      .grant_addr_i       (grant_addr[c]),
      .grant_data_i       (grant_data[c]),
      .cons_read_valid_i  (ch_rd_valid[c]),
      .cons_write_valid_i (ch_wr_valid[c]),
      .state_o            (ch_state[c]),
      .idx_o              (ch_idx[c]),
      .ptr_o              (ch_ptr[c]),
      .data_o             (ch_data[c]),
      .release_o          (ch_release[c]),
      .mem_read_valid_o   (mem_read_valid[c]),
      .mem_read_address_o (mem_read_address[c]),
      .mem_read_ready_i   (mem_read_ready[c]),
      .mem_read_data_i    (mem_read_data[c]),
      .mem_write_valid_o  (mem_write_valid[c]),
      .mem_write_address_o(mem_write_address[c]),
      .mem_write_data_o   (mem_write_data[c]),
      .mem_write_ready_i  (mem_write_ready[c])
    );
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench: one single-channel and one dual-channel controller.
// Write expectations follow MEM_CONTROLLER_WRITE_EN.
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]      rv1, rr1, wv1, wr1;
  logic [3:0][7:0] ra1, rd1, wa1, wd1;
  logic [0:0]      mrv1, mrr1, mwv1, mwr1;
  logic [0:0][7:0] mra1, mrd1, mwa1, mwd1;

  logic [3:0]      rv2, rr2, wv2, wr2;
  logic [3:0][7:0] ra2, rd2, wa2, wd2;
  logic [1:0]      mrv2, mrr2, mwv2, mwr2;
  logic [1:0][7:0] mra2, mrd2, mwa2, mwd2;

  mem_controller #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(1),
    .ADDR_BITS(8), .DATA_BITS(8)
  ) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv1), .consumer_read_address(ra1),
    .consumer_read_ready(rr1), .consumer_read_data(rd1),
    .consumer_write_valid(wv1), .consumer_write_address(wa1),
    .consumer_write_data(wd1), .consumer_write_ready(wr1),
    .mem_read_valid(mrv1), .mem_read_address(mra1),
    .mem_read_ready(mrr1), .mem_read_data(mrd1),
    .mem_write_valid(mwv1), .mem_write_address(mwa1),
    .mem_write_data(mwd1), .mem_write_ready(mwr1)
  );

  mem_controller #(
    .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
    .ADDR_BITS(8), .DATA_BITS(8)
  ) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv2), .consumer_read_address(ra2),
    .consumer_read_ready(rr2), .consumer_read_data(rd2),
    .consumer_write_valid(wv2), .consumer_write_address(wa2),
    .consumer_write_data(wd2), .consumer_write_ready(wr2),
    .mem_read_valid(mrv2), .mem_read_address(mra2),
    .mem_read_ready(mrr2), .mem_read_data(mrd2),
    .mem_write_valid(mwv2), .mem_write_address(mwa2),
    .mem_write_data(mwd2), .mem_write_ready(mwr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv1 = '0; wv1 = '0; mrr1 = '0; mwr1 = '0; mrd1 = '0;
    rv2 = '0; wv2 = '0; mrr2 = '0; mwr2 = '0; mrd2 = '0;
    tick();
    reset = 1'b0;
  endtask

  // Grant, zero-latency memory response, consumer drop.
  task automatic serve1(input int i, input logic [7:0] addr,
                        input logic [7:0] dat);
    tick();
    check($sformatf("grant_valid_c%0d", i), 32'(mrv1), 32'h1);
    check($sformatf("grant_addr_c%0d", i), 32'(mra1), 32'(addr));
    mrr1 = 1'b1; mrd1 = dat;
    tick();
    mrr1 = 1'b0; mrd1 = '0;
    check($sformatf("rd_ready_c%0d", i), 32'(rr1), 32'(1) << i);
    check($sformatf("rd_data_c%0d", i), 32'(rd1[i]), 32'(dat));
    check($sformatf("mem_valid_drop_c%0d", i), 32'(mrv1), 32'h0);
    rv1[i] = 1'b0;
    tick();
    check($sformatf("rd_release_c%0d", i), 32'(rr1), 32'h0);
  endtask

  initial begin
    ra1 = '0; wa1 = '0; wd1 = '0;
    ra2 = '0; wa2 = '0; wd2 = '0;
    do_reset();
    reset = 1'b1;
    tick();
    check("rst_rr1", 32'(rr1), 0);
    check("rst_rd1", rd1, 0);
    check("rst_mrv1", 32'(mrv1), 0);
    check("rst_mwv1", 32'(mwv1), 0);
    check("rst_wr1", 32'(wr1), 0);
    check("rst_mrv2", 32'(mrv2), 0);
    check("rst_mra2", 32'(mra2), 0);
    reset = 1'b0;

    // single read by consumer 2
    rv1[2] = 1'b1; ra1[2] = 8'h10;
    tick();
    check("t1_mrv", 32'(mrv1), 1);
    check("t1_mra", 32'(mra1), 32'h10);
    check("t1_rr_early", 32'(rr1), 0);
    mrr1 = 1'b1; mrd1 = 8'hAB;
    tick();
    mrr1 = 1'b0; mrd1 = '0;
    check("t1_rr", 32'(rr1), 32'b0100);
    check("t1_rd", 32'(rd1[2]), 32'hAB);
    check("t1_mrv_drop", 32'(mrv1), 0);
    tick();
    check("t1_rr_hold", 32'(rr1), 32'b0100);
    check("t1_rd_hold", 32'(rd1[2]), 32'hAB);
    rv1[2] = 1'b0;
    tick();
    check("t1_rr_low", 32'(rr1), 0);

    // all four at once, then rotation
    do_reset();
    ra1 = {8'h43, 8'h42, 8'h41, 8'h40};
    rv1 = 4'hF;
    serve1(0, 8'h40, 8'hC0);
    serve1(1, 8'h41, 8'hC1);
    serve1(2, 8'h42, 8'hC2);
    serve1(3, 8'h43, 8'hC3);
    rv1[1] = 1'b1; rv1[3] = 1'b1;
    serve1(1, 8'h41, 8'hD1);
    serve1(3, 8'h43, 8'hD3);
    rv1[0] = 1'b1; rv1[2] = 1'b1;
    serve1(0, 8'h40, 8'hE0);
    serve1(2, 8'h42, 8'hE2);

    // two channels, same-cycle claims
    do_reset();
    ra2 = {8'h33, 8'h32, 8'h31, 8'h30};
    rv2 = 4'b0111;
    tick();
    check("t3_mrv", 32'(mrv2), 32'b11);
    check("t3_mra", 32'(mra2), 32'h3130);
    mrr2 = 2'b11; mrd2 = {8'h91, 8'h90};
    tick();
    mrr2 = '0; mrd2 = '0;
    check("t3_rr", 32'(rr2), 32'b0011);
    check("t3_rd", 32'(rd2[1:0]), 32'h9190);
    check("t3_mrv_drop", 32'(mrv2), 0);
    tick();
    check("t3_no_dup", 32'(mrv2), 0);
    check("t3_rr_hold", 32'(rr2), 32'b0011);
    rv2[0] = 1'b0; rv2[1] = 1'b0;
    tick();
    check("t3_rr_low", 32'(rr2), 0);
    tick();
    check("t3_c2_mrv", 32'(mrv2), 32'b01);
    check("t3_c2_mra", 32'(mra2[0]), 32'h32);
    mrr2[0] = 1'b1; mrd2[0] = 8'h92;
    tick();
    mrr2 = '0; mrd2 = '0;
    check("t3_c2_rr", 32'(rr2), 32'b0100);
    check("t3_c2_rd", 32'(rd2[2]), 32'h92);
    rv2[2] = 1'b0;
    tick();
    check("t3_c2_rr_low", 32'(rr2), 0);

`ifdef MEM_CONTROLLER_WRITE_EN
    // delayed write acknowledge
    do_reset();
    wv1[1] = 1'b1; wa1[1] = 8'h22; wd1[1] = 8'h5C;
    tick();
    check("t4_mwv", 32'(mwv1), 1);
    check("t4_mwa", 32'(mwa1), 32'h22);
    check("t4_mwd", 32'(mwd1), 32'h5C);
    check("t4_mrv", 32'(mrv1), 0);
    wa1[1] = 8'h99; wd1[1] = 8'hFF;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("t4_mwv_hold", 32'(mwv1), 1);
      check("t4_mwa_hold", 32'(mwa1), 32'h22);
      check("t4_mwd_hold", 32'(mwd1), 32'h5C);
      check("t4_wr_early", 32'(wr1), 0);
    end
    mwr1 = 1'b1;
    tick();
    mwr1 = 1'b0;
    check("t4_wr", 32'(wr1), 32'b0010);
    check("t4_mwv_drop", 32'(mwv1), 0);
    tick();
    check("t4_wr_hold", 32'(wr1), 32'b0010);
    wv1[1] = 1'b0;
    tick();
    check("t4_wr_low", 32'(wr1), 0);
`else
    // read-only build: writes ignored, reads still served
    do_reset();
    wv1[0] = 1'b1; wa1[0] = 8'h22; wd1[0] = 8'h5C;
    ra1[1] = 8'h55; rv1[1] = 1'b1;
    serve1(1, 8'h55, 8'h66);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("t6_mwv", 32'(mwv1), 0);
      check("t6_mwa", 32'(mwa1), 0);
      check("t6_wr", 32'(wr1), 0);
      check("t6_mrv", 32'(mrv1), 0);
    end
    wv1[0] = 1'b0;
`endif

    // reset during READ_WAITING
    do_reset();
    rv1[3] = 1'b1; ra1[3] = 8'h77;
    tick();
    check("t5_mrv", 32'(mrv1), 1);
    check("t5_mra", 32'(mra1), 32'h77);
    reset = 1'b1; rv1[3] = 1'b0;
    tick();
    check("t5_rst_mrv", 32'(mrv1), 0);
    check("t5_rst_mra", 32'(mra1), 0);
    check("t5_rst_rr", 32'(rr1), 0);
    check("t5_rst_rd", rd1, 0);
    reset = 1'b0;
    mrr1 = 1'b1; mrd1 = 8'hEE;
    tick();
    mrr1 = 1'b0; mrd1 = '0;
    check("t5_late_rr", 32'(rr1), 0);
    check("t5_late_rd", rd1, 0);
    check("t5_late_mrv", 32'(mrv1), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
